key_ctrl: RTL and testbench

- Consumes the 9-bit scan word produced by the PS/2 scan stage: 0 while no key is held; {extend, keycode} while a key is pressed.
- Converts that word into game-control signals for the race logic:
  - per-control held levels,
  - one-cycle press pulses,
  - auto-repeat pulses while a control stays held.
- Sits between the PS/2 scanner and the game FSM, in the same clock domain.

---
 rtl/key_ctrl.sv | 80 ++++++++
 tb/tb_key_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_ctrl.sv
// key_ctrl: maps PS/2 scan words to held levels, press pulses and auto-repeat pulses
module key_ctrl #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] crt_data,
  output logic [7:0] key_held,
  output logic [7:0] key_press,
  output logic [7:0] key_repeat,
  output logic       key_any
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0] prev_q;
  logic [7:0] held_q, held_d, press_q, press_d, rep_q, rep_d, map_new;
  logic any_q, ev, restart, go;
  always_comb begin
    map_new = (crt_data == 9'h175 || crt_data == 9'h01D) ? 8'h01 :
              (crt_data == 9'h172 || crt_data == 9'h01B) ? 8'h02 :
              (crt_data == 9'h16B || crt_data == 9'h01C) ? 8'h04 :
              (crt_data == 9'h174 || crt_data == 9'h023) ? 8'h08 :
              (crt_data == 9'h029) ? 8'h10 :
              (crt_data == 9'h05A) ? 8'h20 :
              (crt_data == 9'h04D) ? 8'h40 :
              (crt_data == 9'h076) ? 8'h80 : 8'h00;
    ev      = crt_data != prev_q;
    held_d  = ev ? map_new : held_q;
    press_d = ev ? (map_new & ~held_q) : 8'h00;
    restart = ev && (map_new != held_q);
    go      = (held_d != 8'h00) && REPEAT_EN;
  end
  // DELAY starts at cnt=1 on the press edge, so matching REPEAT_DELAY lands the first repeat REPEAT_DELAY cycles after the press
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = 8'h00;
    if (restart || held_d == 8'h00 || (state_q == IDLE && go)) begin
      state_d = go ? DELAY : IDLE;
      cnt_d   = go ? CNT_ONE : '0;
    end else if (state_q == DELAY) begin
      state_d = (cnt_q == DLY_END) ? REPEAT : DELAY;
      rep_d   = (cnt_q == DLY_END) ? held_q : 8'h00;
      cnt_d   = (cnt_q == DLY_END) ? '0 : cnt_q + CNT_ONE;
    end else if (state_q == REPEAT) begin
      rep_d   = (cnt_q == PER_END) ? held_q : 8'h00;
      cnt_d   = (cnt_q == PER_END) ? '0 : cnt_q + CNT_ONE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      held_q  <= '0;
      press_q <= '0;
      rep_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= crt_data;
      held_q  <= held_d;
      press_q <= press_d;
      rep_q   <= rep_d;
      any_q   <= |held_d;
    end
  end
  assign key_held   = held_q;
  assign key_press  = press_q;
  assign key_repeat = rep_q;
  assign key_any    = any_q;
endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed checks of key_ctrl with short repeat timing, plus a repeat-disabled instance
module tb_key_ctrl;
  logic clk, rst;
  logic [8:0] crt_a, crt_b;
  logic [7:0] held_a, press_a, rep_a, held_b, press_b, rep_b;
  logic any_a, any_b;
  logic [24:0] obs_a, obs_b, exp_v;
  int n_cmp, n_err;

  key_ctrl #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_W(4), .REPEAT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .crt_data(crt_a),
    .key_held(held_a), .key_press(press_a), .key_repeat(rep_a), .key_any(any_a));
  key_ctrl #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_W(4), .REPEAT_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .crt_data(crt_b),
    .key_held(held_b), .key_press(press_b), .key_repeat(rep_b), .key_any(any_b));

  assign obs_a = {held_a, press_a, rep_a, any_a};
  assign obs_b = {held_b, press_b, rep_b, any_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; crt_a = 9'h000; crt_b = 9'h000;
    step(); step();
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL reset_a got=%h exp=%h", obs_a, 25'h0); end
    n_cmp++;
    if (obs_b !== 25'h0) begin n_err++; $display("FAIL reset_b got=%h exp=%h", obs_b, 25'h0); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_repeat();
    crt_a = 9'h01D;
    step();
    n_cmp++; exp_v = {8'h01, 8'h01, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL press_w got=%h exp=%h", obs_a, exp_v); end
    for (int k = 1; k <= 17; k++) begin
      step();
      n_cmp++; exp_v = {8'h01, 8'h00, (k == 8 || k == 12 || k == 16) ? 8'h01 : 8'h00, 1'b1};
      if (obs_a !== exp_v) begin n_err++; $display("FAIL repeat_w k=%0d got=%h exp=%h", k, obs_a, exp_v); end
    end
  endtask

  task automatic test_same_bit();
    crt_a = 9'h000;
    step();
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL release1 got=%h exp=%h", obs_a, 25'h0); end
    crt_a = 9'h175;
    step();
    n_cmp++; exp_v = {8'h01, 8'h01, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL press_up got=%h exp=%h", obs_a, exp_v); end
    for (int k = 1; k <= 13; k++) begin
      if (k == 3) crt_a = 9'h01D;
      step();
      n_cmp++; exp_v = {8'h01, 8'h00, (k == 8 || k == 12) ? 8'h01 : 8'h00, 1'b1};
      if (obs_a !== exp_v) begin n_err++; $display("FAIL same_bit k=%0d got=%h exp=%h", k, obs_a, exp_v); end
    end
  endtask

  task automatic test_switch();
    crt_a = 9'h000;
    step(); step();
    crt_a = 9'h16B;
    step();
    n_cmp++; exp_v = {8'h04, 8'h04, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL press_left got=%h exp=%h", obs_a, exp_v); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; exp_v = {8'h04, 8'h00, 8'h00, 1'b1};
      if (obs_a !== exp_v) begin n_err++; $display("FAIL left_hold k=%0d got=%h exp=%h", k, obs_a, exp_v); end
    end
    crt_a = 9'h029;
    step();
    n_cmp++; exp_v = {8'h10, 8'h10, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL press_fire got=%h exp=%h", obs_a, exp_v); end
    for (int k = 1; k <= 13; k++) begin
      step();
      n_cmp++; exp_v = {8'h10, 8'h00, (k == 8 || k == 12) ? 8'h10 : 8'h00, 1'b1};
      if (obs_a !== exp_v) begin n_err++; $display("FAIL switch k=%0d got=%h exp=%h", k, obs_a, exp_v); end
    end
  endtask

  task automatic test_release();
    crt_a = 9'h000;
    step();
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL release got=%h exp=%h", obs_a, 25'h0); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (obs_a !== 25'h0) begin n_err++; $display("FAIL release_quiet k=%0d got=%h exp=%h", k, obs_a, 25'h0); end
    end
  endtask

  task automatic test_unmapped();
    crt_a = 9'h015;
    for (int k = 0; k <= 10; k++) begin
      step();
      n_cmp++;
      if (obs_a !== 25'h0) begin n_err++; $display("FAIL unmapped k=%0d got=%h exp=%h", k, obs_a, 25'h0); end
    end
    crt_a = 9'h000;
    step();
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL unmapped_rel got=%h exp=%h", obs_a, 25'h0); end
  endtask

  task automatic test_reset_mid();
    crt_a = 9'h076;
    step();
    n_cmp++; exp_v = {8'h80, 8'h80, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL press_esc got=%h exp=%h", obs_a, exp_v); end
    step();
    n_cmp++; exp_v = {8'h80, 8'h00, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL esc_hold got=%h exp=%h", obs_a, exp_v); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL async_rst got=%h exp=%h", obs_a, 25'h0); end
    step();
    n_cmp++;
    if (obs_a !== 25'h0) begin n_err++; $display("FAIL in_rst got=%h exp=%h", obs_a, 25'h0); end
    rst = 1'b1;
    step();
    n_cmp++; exp_v = {8'h80, 8'h80, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL repress_esc got=%h exp=%h", obs_a, exp_v); end
    step();
    n_cmp++; exp_v = {8'h80, 8'h00, 8'h00, 1'b1};
    if (obs_a !== exp_v) begin n_err++; $display("FAIL repress_once got=%h exp=%h", obs_a, exp_v); end
    crt_a = 9'h000;
    step();
  endtask

  task automatic test_no_repeat();
    crt_b = 9'h05A;
    step();
    n_cmp++; exp_v = {8'h20, 8'h20, 8'h00, 1'b1};
    if (obs_b !== exp_v) begin n_err++; $display("FAIL press_enter got=%h exp=%h", obs_b, exp_v); end
    for (int k = 1; k <= 50; k++) begin
      step();
      n_cmp++; exp_v = {8'h20, 8'h00, 8'h00, 1'b1};
      if (obs_b !== exp_v) begin n_err++; $display("FAIL no_repeat k=%0d got=%h exp=%h", k, obs_b, exp_v); end
    end
    crt_b = 9'h000;
    step();
    n_cmp++;
    if (obs_b !== 25'h0) begin n_err++; $display("FAIL enter_rel got=%h exp=%h", obs_b, 25'h0); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_repeat();
    test_same_bit();
    test_switch();
    test_release();
    test_unmapped();
    test_reset_mid();
    test_no_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
